// File: rtl/gen_two_port_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gen_two_port_mem : parametrised synchronous two-port RAM model with lane  |
// | write masks, optional output register, RDW select, COLL and ERR flags.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module gen_two_port_mem #(
  parameter int DEPTH    = 4096,
  parameter int WIDTH    = 32,
  parameter int BYTE_W   = 8,
  parameter int AW       = 12,
  parameter int PIPE     = 0,
  parameter int RDW_MODE = 0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CENA,
  input  logic                      WENA,
  input  logic [WIDTH/BYTE_W-1:0]   BWENA,
  input  logic [AW-1:0]             AA,
  input  logic [WIDTH-1:0]          DA,
  input  logic                      OENA,
  output logic [WIDTH-1:0]          QA,
  output logic                      QVA,
  input  logic                      CENB,
  input  logic                      WENB,
  input  logic [WIDTH/BYTE_W-1:0]   BWENB,
  input  logic [AW-1:0]             AB,
  input  logic [WIDTH-1:0]          DB,
  input  logic                      OENB,
  output logic [WIDTH-1:0]          QB,
  output logic                      QVB,
  output logic                      COLL,
  output logic                      ERR
);

  localparam int            c_NB    = WIDTH / BYTE_W;
  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_en_a, w_en_b;
  logic             w_inr_a, w_inr_b;
  logic             w_wr_a, w_wr_b;
  logic             w_rd_a, w_rd_b;
  logic             w_same;
  logic [AW-1:0]    w_idx_a, w_idx_b;
  logic [WIDTH-1:0] w_bm_a, w_bm_b;
  logic [WIDTH-1:0] w_old_a, w_old_b;
  logic [WIDTH-1:0] w_new_a, w_new_b;
  logic [WIDTH-1:0] w_raw_a, w_raw_b;

  logic [WIDTH-1:0] r_q_a, r_q_b;
  logic             r_qv_a, r_qv_b;
  logic             r_coll, r_err;

  // Apply B's lanes first, then A's, so port A wins wherever both enable a lane.
  function automatic logic [WIDTH-1:0] f_merge(
    input logic [WIDTH-1:0] i_old,
    input logic             i_hit_a,
    input logic [WIDTH-1:0] i_bm_a,
    input logic [WIDTH-1:0] i_d_a,
    input logic             i_hit_b,
    input logic [WIDTH-1:0] i_bm_b,
    input logic [WIDTH-1:0] i_d_b
  );
    logic [WIDTH-1:0] v_w;
    v_w = i_old;
    if (i_hit_b) v_w = (v_w & ~i_bm_b) | (i_d_b & i_bm_b);
    if (i_hit_a) v_w = (v_w & ~i_bm_a) | (i_d_a & i_bm_a);
    return v_w;
  endfunction

  assign w_inr_a = ({1'b0, AA} < c_DEPTH);
  assign w_inr_b = ({1'b0, AB} < c_DEPTH);
  assign w_en_a  = ~RST & ~CENA;
  assign w_en_b  = ~RST & ~CENB;
  assign w_wr_a  = w_en_a & ~WENA & w_inr_a;
  assign w_wr_b  = w_en_b & ~WENB & w_inr_b;
  assign w_rd_a  = w_en_a & WENA;
  assign w_rd_b  = w_en_b & WENB;
  assign w_same  = (AA == AB);

  // Out-of-range requests index word 0 so the array is never read past its end.
  assign w_idx_a = w_inr_a ? AA : '0;
  assign w_idx_b = w_inr_b ? AB : '0;

  genvar gl;
  generate
    for (gl = 0; gl < c_NB; gl++) begin : g_lane
      assign w_bm_a[gl*BYTE_W +: BYTE_W] = {BYTE_W{~BWENA[gl]}};
      assign w_bm_b[gl*BYTE_W +: BYTE_W] = {BYTE_W{~BWENB[gl]}};
    end
  endgenerate

  assign w_old_a = r_mem[w_idx_a];
  assign w_old_b = r_mem[w_idx_b];

  // Post-write word at each port's address; identical when both ports write the same word.
  assign w_new_a = f_merge(w_old_a, w_wr_a, w_bm_a, DA, w_wr_b & w_same, w_bm_b, DB);
  assign w_new_b = f_merge(w_old_b, w_wr_a & w_same, w_bm_a, DA, w_wr_b, w_bm_b, DB);

  assign w_raw_a = ~w_inr_a ? '0 : ((RDW_MODE != 0) ? w_new_a : w_old_a);
  assign w_raw_b = ~w_inr_b ? '0 : ((RDW_MODE != 0) ? w_new_b : w_old_b);

  always_ff @(posedge CLK) begin
    if (w_wr_a) r_mem[w_idx_a] <= w_new_a;
    if (w_wr_b) r_mem[w_idx_b] <= w_new_b;
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] r_p_a, r_p_b;
      logic             r_pv_a, r_pv_b;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_p_a  <= '0;
          r_p_b  <= '0;
          r_pv_a <= 1'b0;
          r_pv_b <= 1'b0;
          r_q_a  <= '0;
          r_q_b  <= '0;
          r_qv_a <= 1'b0;
          r_qv_b <= 1'b0;
        end else begin
          r_pv_a <= w_rd_a;
          r_pv_b <= w_rd_b;
          if (w_rd_a) r_p_a <= w_raw_a;
          if (w_rd_b) r_p_b <= w_raw_b;
          r_qv_a <= r_pv_a;
          r_qv_b <= r_pv_b;
          if (r_pv_a) r_q_a <= r_p_a;
          if (r_pv_b) r_q_b <= r_p_b;
        end
      end
    end else begin : g_nopipe
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q_a  <= '0;
          r_q_b  <= '0;
          r_qv_a <= 1'b0;
          r_qv_b <= 1'b0;
        end else begin
          r_qv_a <= w_rd_a;
          r_qv_b <= w_rd_b;
          if (w_rd_a) r_q_a <= w_raw_a;
          if (w_rd_b) r_q_b <= w_raw_b;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_coll <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_coll <= w_wr_a & w_wr_b & w_same;
      r_err  <= r_err | (w_en_a & ~w_inr_a) | (w_en_b & ~w_inr_b);
    end
  end

  assign QA   = OENA ? '0 : r_q_a;
  assign QB   = OENB ? '0 : r_q_b;
  assign QVA  = r_qv_a;
  assign QVB  = r_qv_b;
  assign COLL = r_coll;
  assign ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gen_two_port_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gen_two_port_mem : scoreboard bench over four PIPE/RDW_MODE builds     |
// | sharing one stimulus stream and one word-level reference model.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gen_two_port_mem;

  localparam int DEPTH = 3000;
  localparam int NRAND = 3000;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cena, wena, oena, cenb, wenb, oenb;
  logic [3:0]  bwena, bwenb;
  logic [11:0] aa, ab;
  logic [31:0] da, db;

  logic [31:0] w_q   [8];
  logic        w_qv  [8];
  logic        w_coll[4];
  logic        w_err [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      logic [31:0] qa, qb;
      logic        qva, qvb, coll, err;
      gen_two_port_mem #(
        .DEPTH(DEPTH), .WIDTH(32), .BYTE_W(8), .AW(12),
        .PIPE(gi % 2), .RDW_MODE(gi / 2)
      ) u_dut (
        .CLK(clk), .RST(rst),
        .CENA(cena), .WENA(wena), .BWENA(bwena), .AA(aa), .DA(da), .OENA(oena),
        .QA(qa), .QVA(qva),
        .CENB(cenb), .WENB(wenb), .BWENB(bwenb), .AB(ab), .DB(db), .OENB(oenb),
        .QB(qb), .QVB(qvb),
        .COLL(coll), .ERR(err)
      );
      assign w_q[2*gi]    = qa;
      assign w_q[2*gi+1]  = qb;
      assign w_qv[2*gi]   = qva;
      assign w_qv[2*gi+1] = qvb;
      assign w_coll[gi]   = coll;
      assign w_err[gi]    = err;
    end
  endgenerate

  int          edges = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          done = 1'b0;
  logic [31:0] mdl [DEPTH];
  exp_t        q_exp [8][$];
  bit          rst_at [int];
  bit          coll_at[int];
  bit          err_at [int];
  logic [31:0] last_q [8];
  bit          err_exp = 1'b0;

  always @(posedge clk) edges = edges + 1;

  task automatic chk(input string name, input int s, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s stream=%0d edge=%0d got=%h expected=%h", name, s, edges, got, expv);
    end
  endtask

  // Monitor: streams 2c/2c+1 are ports A/B of build c (PIPE=c%2, RDW_MODE=c/2).
  always @(negedge clk) begin
    if (edges >= 1 && !done) begin
      exp_t e;
      bit   exp_v;
      bit   oen;
      if (rst_at.exists(edges)) begin
        for (int s = 0; s < 8; s++) last_q[s] = '0;
        err_exp = 1'b0;
      end else if (err_at.exists(edges)) begin
        err_exp = 1'b1;
      end
      for (int s = 0; s < 8; s++) begin
        exp_v = 1'b0;
        if (q_exp[s].size() > 0 && q_exp[s][0].due == edges) begin
          e = q_exp[s].pop_front();
          exp_v = 1'b1;
          last_q[s] = e.data;
        end
        chk("qv", s, {31'b0, w_qv[s]}, {31'b0, exp_v});
        oen = (s % 2 == 0) ? oena : oenb;
        chk("q", s, w_q[s], oen ? 32'h0 : last_q[s]);
      end
      for (int c = 0; c < 4; c++) begin
        chk("coll", c, {31'b0, w_coll[c]}, {31'b0, coll_at.exists(edges)});
        chk("err",  c, {31'b0, w_err[c]},  {31'b0, err_exp});
      end
    end
  end

  function automatic logic [31:0] merged(input logic [11:0] a, input bit hit_a, input bit hit_b);
    logic [31:0] w;
    w = mdl[a];
    for (int l = 0; l < 4; l++) begin
      if (hit_a && !bwena[l])      w[l*8 +: 8] = da[l*8 +: 8];
      else if (hit_b && !bwenb[l]) w[l*8 +: 8] = db[l*8 +: 8];
    end
    return w;
  endfunction

  // Evaluate the reference model for the upcoming edge, then advance one cycle.
  task automatic tick();
    int          m;
    bit          ina, inb, wra, wrb, rda, rdb;
    logic [31:0] olda, oldb, newa, newb;
    exp_t        e;
    m = edges;
    if (rst) begin
      rst_at[m+1] = 1'b1;
      for (int s = 0; s < 8; s++)
        while (q_exp[s].size() > 0 && q_exp[s][$].due >= m + 1) void'(q_exp[s].pop_back());
    end else begin
      ina = (int'(aa) < DEPTH);
      inb = (int'(ab) < DEPTH);
      wra = !cena && !wena && ina;
      wrb = !cenb && !wenb && inb;
      rda = !cena && wena;
      rdb = !cenb && wenb;
      if ((!cena && !ina) || (!cenb && !inb)) err_at[m+1] = 1'b1;
      if (wra && wrb && aa == ab) coll_at[m+1] = 1'b1;
      olda = ina ? mdl[aa] : 32'h0;
      oldb = inb ? mdl[ab] : 32'h0;
      newa = ina ? merged(aa, wra, wrb && ab == aa) : 32'h0;
      newb = inb ? merged(ab, wra && aa == ab, wrb) : 32'h0;
      for (int c = 0; c < 4; c++) begin
        if (rda) begin
          e.due  = m + 1 + (c % 2);
          e.data = (c / 2 == 1) ? newa : olda;
          q_exp[2*c].push_back(e);
        end
        if (rdb) begin
          e.due  = m + 1 + (c % 2);
          e.data = (c / 2 == 1) ? newb : oldb;
          q_exp[2*c+1].push_back(e);
        end
      end
      if (wra) mdl[aa] = newa;
      if (wrb) mdl[ab] = newb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cena = 1'b1; wena = 1'b1; bwena = 4'hF; aa = '0; da = '0;
    cenb = 1'b1; wenb = 1'b1; bwenb = 4'hF; ab = '0; db = '0;
  endtask

  task automatic op_a(input bit wr, input logic [3:0] be, input int a, input logic [31:0] d);
    cena = 1'b0; wena = !wr; bwena = be; aa = 12'(a); da = d;
  endtask

  task automatic op_b(input bit wr, input logic [3:0] be, input int a, input logic [31:0] d);
    cenb = 1'b0; wenb = !wr; bwenb = be; ab = 12'(a); db = d;
  endtask

  function automatic int pick_addr();
    if ($urandom_range(0, 19) == 0) return 3000 + int'($urandom_range(0, 1095));
    return int'($urandom_range(0, 15));
  endfunction

  initial begin
    rst = 1'b1; oena = 1'b0; oenb = 1'b0;
    idle();
    repeat (3) tick();
    rst = 1'b0;

    for (int a = 0; a < 32; a += 2) begin
      idle(); op_a(1, 4'h0, a, $urandom); op_b(1, 4'h0, a + 1, $urandom); tick();
    end

    // Contents survive reset; requests during reset are ignored.
    idle(); op_a(1, 4'h0, 5, 32'hDEADBEEF); tick();
    idle(); rst = 1'b1; op_a(0, 4'h0, 5, 0); op_b(1, 4'h0, 6, 32'hFFFF0000); tick(); tick();
    rst = 1'b0; idle(); op_a(0, 4'h0, 5, 0); op_b(0, 4'h0, 6, 0); tick();
    idle(); repeat (2) tick();

    // Byte-lane mask.
    idle(); op_a(1, 4'h0, 10, 32'h11223344); tick();
    idle(); op_a(1, 4'b1010, 10, 32'hAABBCCDD); tick();
    idle(); op_a(0, 4'h0, 10, 0); tick();
    idle(); repeat (2) tick();

    // Back-to-back reads.
    for (int a = 0; a < 8; a++) begin
      idle(); op_a(0, 4'h0, a, 0); op_b(0, 4'h0, 7 - a, 0); tick();
    end
    idle(); repeat (3) tick();

    // Cross-port read during write.
    idle(); op_a(1, 4'h0, 7, 32'h1); tick();
    idle(); op_a(0, 4'h0, 7, 0); op_b(1, 4'h0, 7, 32'h2); tick();
    idle(); op_b(0, 4'h0, 7, 0); tick();
    idle(); repeat (2) tick();

    // Same-address collision.
    idle(); op_a(1, 4'b0011, 3, 32'hAAAAAAAA); op_b(1, 4'h0, 3, 32'h55555555); tick();
    idle(); op_a(0, 4'h0, 3, 0); tick();
    idle(); repeat (2) tick();

    // Out of range, sticky ERR, output enable.
    idle(); op_a(1, 4'h0, 3000, 32'hCAFEF00D); tick();
    idle(); op_a(0, 4'h0, 3000, 0); tick();
    idle(); repeat (3) tick();
    oena = 1'b1; idle(); op_a(0, 4'h0, 5, 0); tick();
    idle(); repeat (2) tick();
    oena = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; idle(); repeat (2) tick();

    for (int i = 0; i < NRAND; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      cena  = ($urandom_range(0, 3) == 0);
      wena  = 1'($urandom_range(0, 1));
      bwena = 4'($urandom);
      aa    = 12'(pick_addr());
      da    = $urandom;
      oena  = ($urandom_range(0, 9) == 0);
      cenb  = ($urandom_range(0, 3) == 0);
      wenb  = 1'($urandom_range(0, 1));
      bwenb = 4'($urandom);
      ab    = 12'(pick_addr());
      db    = $urandom;
      oenb  = ($urandom_range(0, 9) == 0);
      tick();
    end

    rst = 1'b0; oena = 1'b0; oenb = 1'b0; idle();
    repeat (6) tick();
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
